// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular arbiter that shares the async FIFO write port among NREQ wclk-domain producers.
// Optional macro FIFO_WR_ARB_TAG_EN: each grant first writes a header beat holding the requester index.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

`ifdef FIFO_WR_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, XFER, HDR} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_nx;
  logic [IW-1:0]   last_gnt, last_gnt_nx;
  logic [IW-1:0]   cand, pick;
  logic            found;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            take;

  // Rotating priority search: first requester above last_gnt, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = last_gnt;
    cand  = last_gnt;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_gnt) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    last_gnt_nx = last_gnt;
    cnt_nx      = cnt;
    req_ready   = '0;
    winc        = 1'b0;
    wdata       = '0;
    take        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx       = '0;
          grant_nx[pick] = 1'b1;
          last_gnt_nx    = pick;
          cnt_nx         = '0;
`ifdef FIFO_WR_ARB_TAG_EN
          state_nx       = HDR;
`else
          state_nx       = XFER;
`endif
        end
      end
`ifdef FIFO_WR_ARB_TAG_EN
      HDR: begin
        winc  = !wfull;
        wdata = DSIZE'(last_gnt);
        if (!wfull) state_nx = XFER;
      end
`endif
      XFER: begin
        take      = req[last_gnt] && !wfull;
        req_ready = grant & {NREQ{!wfull}};
        winc      = take;
        wdata     = req_data[last_gnt*DSIZE +: DSIZE];
        // Release on end of packet or when the burst budget is used up.
        if (take) begin
          cnt_nx = cnt + 1'b1;
          if (req_last[last_gnt] || cnt == CW'(MAX_BURST - 1)) begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      grant    <= '0;
      last_gnt <= IW'(NREQ - 1);
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      last_gnt <= last_gnt_nx;
      cnt      <= cnt_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues feed the DUT, observed FIFO writes are compared to expected beats.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int MAXB = 4;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                  wclk, wrst_n;
  logic [NREQ-1:0]       req, req_last, req_ready, grant;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull, winc, busy;
  logic [DSIZE-1:0]      wdata;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAXB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata), .grant(grant), .busy(busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] gnt;
    int         t;
  } beat_t;

  logic [8:0] pq [NREQ][$];
  beat_t      exp_q[$];
  beat_t      cap_q[$];
  int         total = 0, bad = 0, cyc = 0, viol = 0;

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // One cycle: drive producer heads, sample outputs, retire beats the DUT takes at the next edge.
  task automatic tick();
    beat_t b;
    @(negedge wclk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (pq[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[i*DSIZE +: DSIZE] = pq[i][0][7:0];
        req_last[i] = pq[i][0][8];
      end else begin
        req[i] = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
        req_last[i] = 1'b0;
      end
    end
    #1;
    if (winc) begin
      b.data = wdata;
      b.gnt = grant;
      b.t = cyc;
      cap_q.push_back(b);
      if (wfull) viol++;
    end
    for (int i = 0; i < NREQ; i++)
      if (req[i] && req_ready[i]) void'(pq[i].pop_front());
  endtask

  task automatic drain(input int budget, output bit ok);
    bit empty;
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      tick();
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) empty = 1'b0;
      if (empty && !busy) ok = 1'b1;
    end
  endtask

  task automatic load(input int src, input int base, input int n, input int step);
    for (int k = 0; k < n; k++) pq[src].push_back({(k == n - 1), 8'(base + k * step)});
  endtask

  task automatic exp_pkt(input int src, input int base, input int n, input int step, input int gap0);
    beat_t b;
    int g;
    g = gap0;
    b.gnt = 4'(1 << src);
`ifdef FIFO_WR_ARB_TAG_EN
    b.data = 8'(src);
    b.t = g;
    exp_q.push_back(b);
    g = 1;
`endif
    for (int k = 0; k < n; k++) begin
      b.data = 8'(base + k * step);
      b.t = (k == 0) ? g : 1;
      exp_q.push_back(b);
    end
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0;
    wfull = 1'b0;
    req = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) pq[i].delete();
    exp_q.delete();
    cap_q.delete();
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wfull = 1'b0;
    req = 4'b1111;
    req_last = 4'b0000;
    req_data = 32'hA1B2C3D4;
    #12;
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL rst_winc got=%b want=0", winc); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b want=0000", req_ready); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h want=00", wdata); end
    apply_reset();
  endtask

  task automatic test_single();
    bit ok;
    int c0, prev;
    beat_t c, e;
    apply_reset();
    load(0, 8'h11, 3, 8'h11);
    exp_pkt(0, 8'h11, 3, 8'h11, 0);
    c0 = cyc + 1;
    drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done got=timeout want=idle"); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL single_grant_end got=%b want=0000", grant); end
    total++;
    if (cap_q.size() == 0 || cap_q[0].t != c0 + 1) begin
      bad++; $display("FAIL single_latency got_writes=%0d want_first_cycle=%0d", cap_q.size(), c0 + 1);
    end
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    prev = 0;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (c.data !== e.data || c.gnt !== e.gnt || (e.t != 0 && c.t - prev != e.t)) begin
        bad++; $display("FAIL single_beat got data=%h gnt=%b gap=%0d want data=%h gnt=%b gap=%0d", c.data, c.gnt, c.t - prev, e.data, e.gnt, e.t);
      end
      prev = c.t;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int prev;
    beat_t c, e;
    apply_reset();
    load(0, 8'h01, 2, 1); load(0, 8'h03, 2, 1);
    load(2, 8'h21, 2, 1); load(2, 8'h23, 2, 1);
    exp_pkt(0, 8'h01, 2, 1, 0); exp_pkt(2, 8'h21, 2, 1, 2);
    exp_pkt(0, 8'h03, 2, 1, 2); exp_pkt(2, 8'h23, 2, 1, 2);
    drain(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_done got=timeout want=idle"); end
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    prev = 0;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (c.data !== e.data || c.gnt !== e.gnt || (e.t != 0 && c.t - prev != e.t)) begin
        bad++; $display("FAIL rr_beat got data=%h gnt=%b gap=%0d want data=%h gnt=%b gap=%0d", c.data, c.gnt, c.t - prev, e.data, e.gnt, e.t);
      end
      prev = c.t;
    end
  endtask

  task automatic test_stall();
    bit ok;
    int prev;
    beat_t c, e;
    apply_reset();
    load(1, 8'h41, 4, 1);
    exp_pkt(1, 8'h41, 4, 1, 0);
    exp_q[exp_q.size() - 2].t = 6;
    for (int n = 0; n < 40 && cap_q.size() < HDR + 2; n++) tick();
    wfull = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      total++;
      if (winc !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0010) begin
        bad++; $display("FAIL stall_hold got winc=%b ready=%b grant=%b want winc=0 ready=0000 grant=0010", winc, req_ready, grant);
      end
    end
    wfull = 1'b0;
    drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_done got=timeout want=idle"); end
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    prev = 0;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (c.data !== e.data || c.gnt !== e.gnt || (e.t != 0 && c.t - prev != e.t)) begin
        bad++; $display("FAIL stall_beat got data=%h gnt=%b gap=%0d want data=%h gnt=%b gap=%0d", c.data, c.gnt, c.t - prev, e.data, e.gnt, e.t);
      end
      prev = c.t;
    end
  endtask

  task automatic test_burst_limit();
    bit ok;
    int prev;
    beat_t c, e;
    apply_reset();
    load(1, 8'h11, 6, 1);
    load(3, 8'h31, 2, 1);
    exp_pkt(1, 8'h11, 4, 1, 0);
    exp_pkt(3, 8'h31, 2, 1, 2);
    exp_pkt(1, 8'h15, 2, 1, 2);
    drain(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_done got=timeout want=idle"); end
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL burst_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    prev = 0;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (c.data !== e.data || c.gnt !== e.gnt || (e.t != 0 && c.t - prev != e.t)) begin
        bad++; $display("FAIL burst_beat got data=%h gnt=%b gap=%0d want data=%h gnt=%b gap=%0d", c.data, c.gnt, c.t - prev, e.data, e.gnt, e.t);
      end
      prev = c.t;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int prev;
    beat_t c, e;
    apply_reset();
    load(0, 8'h01, 4, 1);
    for (int n = 0; n < 40 && cap_q.size() < HDR + 2; n++) tick();
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    total++;
    if (grant !== 4'b0 || busy !== 1'b0 || winc !== 1'b0 || req_ready !== 4'b0 || wdata !== 8'h00) begin
      bad++; $display("FAIL midrst_outputs got grant=%b busy=%b winc=%b ready=%b wdata=%h want all zero", grant, busy, winc, req_ready, wdata);
    end
    apply_reset();
    for (int i = 0; i < NREQ; i++) load(i, 16 * i + 8'h0A, 1, 1);
    exp_pkt(0, 8'h0A, 1, 1, 0); exp_pkt(1, 8'h1A, 1, 1, 2);
    exp_pkt(2, 8'h2A, 1, 1, 2); exp_pkt(3, 8'h3A, 1, 1, 2);
    drain(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_done got=timeout want=idle"); end
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", cap_q.size(), exp_q.size()); end
    prev = 0;
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (c.data !== e.data || c.gnt !== e.gnt || (e.t != 0 && c.t - prev != e.t)) begin
        bad++; $display("FAIL midrst_beat got data=%h gnt=%b gap=%0d want data=%h gnt=%b gap=%0d", c.data, c.gnt, c.t - prev, e.data, e.gnt, e.t);
      end
      prev = c.t;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL winc_while_full got=%0d want=0", viol); end
  endtask

`ifdef FIFO_WR_ARB_TAG_EN
  task automatic test_tag();
    bit ok;
    beat_t c, e;
    apply_reset();
    load(2, 8'hA5, 1, 1);
    exp_pkt(2, 8'hA5, 1, 1, 0);
    drain(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL tag_done got=timeout want=idle"); end
    total++; if (cap_q.size() != 2) begin bad++; $display("FAIL tag_count got=%0d want=2", cap_q.size()); end
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front(); e = exp_q.pop_front();
      total++;
      if (c.data !== e.data || c.gnt !== e.gnt) begin
        bad++; $display("FAIL tag_beat got data=%h gnt=%b want data=%h gnt=%b", c.data, c.gnt, e.data, e.gnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_burst_limit();
    test_reset_mid();
`ifdef FIFO_WR_ARB_TAG_EN
    test_tag();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-granular arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the wclk domain.
- Holds a grant for a whole packet, until the beat carrying `last` is accepted, or until MAX_BURST beats have been accepted.
- Drives winc/wdata straight into the FIFO write side and obeys wfull.
- Sits between the write-domain producers and the FIFO.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width; must match the FIFO data width.
- MAX_BURST, 16, maximum beats per grant before forced release (1..255).

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester valid; bit i belongs to requester i.
- req_data  input  NREQ*DSIZE  flattened data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_last  input  NREQ  final beat of packet for requester i.
- req_ready  output  NREQ  beat accepted for requester i this cycle when req[i] && req_ready[i].
- wfull  input  1  FIFO full flag.
- winc  output  1  FIFO write enable.
- wdata  output  DSIZE  FIFO write data.
- grant  output  NREQ  one-hot current owner; all zero when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, wrst_n low):
  - state=IDLE.
  - grant=0, busy=0, winc=0, req_ready=0, wdata=0.
  - Round-robin pointer last_gnt=NREQ-1, so requester 0 has top priority after reset.
  - Beat counter=0.
- States: IDLE, XFER; plus HDR when the optional feature is enabled.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from last_gnt+1 with wrap-around.
  - Register it in grant and last_gnt, clear the beat counter, and move to XFER (or HDR) on the next edge.
  - This gives a one-cycle arbitration bubble. No req means stay in IDLE.
- XFER, combinational outputs with 0-cycle latency:
  - req_ready[g] = !wfull; all other req_ready bits are 0.
  - winc = req[g] && !wfull.
  - wdata = req_data of g, regardless of winc.
- Accepted beat: the beat counter increments.
  - If req_last[g] is set, or the counter reaches MAX_BURST, the next state is IDLE and grant clears.
  - Otherwise stay in XFER.
- Counter width is enough to hold MAX_BURST; it never wraps.
- A forced release at MAX_BURST splits the packet. The remainder re-arbitrates like a new request, and other requesters are served first under round-robin.
- If req[g] deasserts mid-packet, the grant is held (packet lock), with no winc and no counter change.
- wfull high: winc=0 and req_ready=0. State and counter hold; a stall has no duration limit.
- wfull is honoured on the same cycle it is seen. The arbiter never asserts winc while wfull=1.
- Requests from non-granted requesters are ignored; their req_ready stays 0.
- Back-to-back packets: after releasing, IDLE always costs exactly one cycle before the next grant.
- Reset asserted mid-packet: return to IDLE immediately. The partial packet already in the FIFO is not recalled.

Optional Feature:
- Macro: FIFO_WR_ARB_TAG_EN.
- Enabled:
  - IDLE moves to HDR instead of XFER.
  - In HDR: winc = !wfull, wdata = requester index zero-extended to DSIZE, and all req_ready bits are 0.
  - On an accepted header beat, move to XFER. The header does not count toward MAX_BURST.
  - A forced-split remainder gets a new header when it is re-granted.
- Disabled: no HDR state; IDLE goes directly to XFER and no header beat is written.

Test Plan:
- Single requester: req[0] drives 3 beats 0x11,0x22,0x33 with last on 0x33, wfull=0 → winc high for 3 consecutive cycles starting one cycle after req; FIFO receives 0x11,0x22,0x33; grant returns to 0 afterwards.
- Round-robin: req[0] and req[2] each hold a 2-beat packet continuously → grant order 0,2,0,2 with a one-idle-cycle gap between packets; no beats interleave.
- Full stall: wfull forced high for 5 cycles mid-packet → winc=0 and req_ready=0 throughout; packet resumes on the beat after wfull falls with no loss or duplication.
- Burst limit: MAX_BURST=4, req[1] sends 6 beats with last on beat 6, req[3] pending → beats 1-4 from req 1, then req 3's packet, then beats 5-6 from req 1.
- Reset mid-packet: wrst_n pulsed low after beat 2 of 4 → outputs go to 0 asynchronously; after release, requester 0 wins when req=4'b1111.
- With FIFO_WR_ARB_TAG_EN: req[2] sends a 1-beat packet 0xA5 → FIFO receives 0x02 then 0xA5.
